// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/start request and product/status bus of the sequential multiplier
interface mult_seq_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     dataa;
   logic [WIDTH-1:0]     datab;
   logic                 busy;
   logic                 done_flag;
   logic [2*WIDTH-1:0]   product_out;

   modport master (
      output start, signed_mode, dataa, datab,
      input  busy, done_flag, product_out
   );

   modport slave (
      input  start, signed_mode, dataa, datab,
      output busy, done_flag, product_out
   );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: shift-add multiplier, one multiplier bit per clock, unsigned or two's-complement operands
module mult_seq #(
   parameter int WIDTH = 4
) (
   input  logic      clk,
   input  logic      reset_a,
   mult_seq_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] mag_a_q, mag_a_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   // Next-state: capture magnitudes on start, accumulate shifted multiplicand per bit, apply sign at the end
   always_comb begin
      state_d = state_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            neg_d   = bus.signed_mode & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
            mag_a_d = (bus.signed_mode & bus.dataa[WIDTH-1]) ? -bus.dataa : bus.dataa;
            mag_b_d = (bus.signed_mode & bus.datab[WIDTH-1]) ? -bus.datab : bus.datab;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: begin
            acc_d   = mag_b_q[0] ? acc_q + (PW'(mag_a_q) << cnt_q) : acc_q;
            mag_b_d = mag_b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? FIN : CALC;
         end
         FIN: begin
            prod_d  = neg_q ? -acc_q : acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any operation without a completion pulse
   always_ff @(posedge clk) begin
      if (reset_a) begin
         state_q <= IDLE;
         mag_a_q <= '0;
         mag_b_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         prod_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done_flag   = done_q;
   assign bus.product_out = prod_q;
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised sequential shift-add multiplier; next generation of the team's 4x4 start/done multiplier.
- Generalised to WIDTH-bit operands, with a per-operation unsigned/signed mode and an explicit busy output.
- Processes one multiplier bit per clock and holds the registered product until the next completion.
- Sits directly behind the TinyTapeout pin wrapper: operands come from ui_in, start and mode from uio_in, and the product and flags drive uo_out/uio_out.

Parameters:
- WIDTH, 4, operand width in bits, >= 2. Product width is 2*WIDTH. Iteration counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock
- reset_a  input  1  reset, synchronous, active-high
- start  input  1  request a multiply; sampled only in IDLE
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start
- dataa  input  WIDTH  multiplicand; sampled with start
- datab  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in flight (CALC or FIN)
- done_flag  output  1  one-cycle pulse when product_out updates
- product_out  output  2*WIDTH  registered product; holds its value between completions

Behaviour:
- One clock. Reset is synchronous and active-high on reset_a. All state updates occur on the rising edge of clk.
- Reset (reset_a=1 at an edge) sets state=IDLE, busy=0, done_flag=0, product_out=0, and clears all internal registers. Reset wins over every other event, including mid-operation; the aborted operation produces no done_flag.
- States: IDLE, CALC, FIN.
- IDLE:
  - busy=0.
  - On an edge with start=1, capture operands and latch neg = signed_mode & (dataa[MSB] ^ datab[MSB]).
  - Unsigned mode: mag_a = dataa, mag_b = datab.
  - Signed mode: mag_a = |dataa|, mag_b = |datab|, each held in WIDTH bits unsigned. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits.
  - Clear acc (2*WIDTH bits) and cnt, then go to CALC.
- CALC:
  - busy=1.
  - Each edge: if mag_b[0], acc <= acc + (mag_a << cnt); then mag_b >>= 1 and cnt++.
  - After WIDTH iterations (cnt reaches WIDTH-1 at the edge), go to FIN.
  - Fixed latency: no early termination on zero operands.
- FIN:
  - busy=1.
  - At the next edge: product_out <= neg ? -acc : acc (2*WIDTH-bit two's complement), done_flag <= 1, state <= IDLE.
- Timing: if start is sampled at edge k, CALC occupies edges k+1..k+WIDTH and product_out/done_flag update at edge k+WIDTH+1. Latency is WIDTH+1 cycles. busy is high from after edge k until edge k+WIDTH+1.
- done_flag:
  - Exactly one cycle wide; deasserted at the next edge unless another completion occurs.
  - A completion can only happen WIDTH+1 cycles after a start, so pulses never merge.
- start, signed_mode, dataa and datab are ignored while busy=1. There is no queuing.
- Back-to-back: start=1 in the cycle where done_flag=1 (state already IDLE) is accepted, giving a sustained throughput of one result per WIDTH+1 cycles.
- Operand changes after the start edge do not affect the in-flight result.
- Width rules:
  - acc never overflows: maximum magnitude is (2^WIDTH-1)^2 unsigned, 2^(2*WIDTH-2) signed.
  - Signed product of zero with any sign yields 0; -0 must not produce a nonzero value.

Test Plan (WIDTH=4):
- Reset, then idle: product_out=0x00, busy=0, done_flag=0. Unsigned 15*15, start pulsed at edge k -> busy high for 5 cycles; at edge k+5 product_out=0xE1 and done_flag=1 for exactly one cycle.
- Signed mode, dataa=0x8 (-8), datab=0x7 -> product_out=0xC8 (-56). dataa=0x8, datab=0x8 -> 0x40 (+64). dataa=0x0, datab=0xF -> 0x00.
- Same bit patterns 0x8*0x8 in unsigned mode -> 0x40; 0xF*0x3 unsigned -> 0x2D; signed (-1*3) -> 0xFD.
- Start held high and dataa/datab changed during CALC -> the original result is produced, no second operation starts until IDLE, and exactly one done_flag per accepted start.
- reset_a asserted at edge k+2 of an operation -> next cycle busy=0, product_out=0, no done_flag; a new start afterwards completes normally.
- Back-to-back: 3*5 then start asserted during the done_flag cycle with 6*7 -> 0x0F, then 0x2A five cycles later, with no idle gap cycle.
